// File: rtl/axi4_pmem_ram_backend.sv
// axi4_pmem_ram_backend: word-addressed RAM target for the pmem bridge ram_* port, fixed-latency in-order acks
module axi4_pmem_ram_backend #(
  parameter int          ADDR_W          = 14,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  ram_wr_i,
  input  logic        ram_rd_i,
  input  logic [7:0]  ram_len_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_write_data_i,
  input  logic        stall_i,
  output logic        ram_accept_o,
  output logic        ram_ack_o,
  output logic        ram_error_o,
  output logic [31:0] ram_read_data_o
);
  logic wr_w, req_w, acc_w, in_range_w, unused_w;
  logic [31:0] off_w;
  logic [ADDR_W-1:0] idx_w;
  logic [2:0] cnt_q;
  logic [LATENCY-1:0] v_q, e_q;
  logic [LATENCY-1:0][31:0] d_q;
  logic [31:0] mem [2**ADDR_W];
  assign wr_w = |ram_wr_i;
  assign req_w = ram_rd_i | wr_w;
  assign acc_w = req_w & ram_accept_o;
  assign off_w = ram_addr_i - BASE_ADDR;
  assign in_range_w = (ram_addr_i >= BASE_ADDR) && (off_w[31:ADDR_W+2] == '0);
  assign idx_w = off_w[ADDR_W+1:2];
  assign unused_w = ^{ram_len_i, off_w[1:0]};
  assign ram_accept_o = !stall_i && (cnt_q != 3'(MAX_OUTSTANDING));
  assign ram_ack_o = v_q[LATENCY-1];
  assign ram_error_o = e_q[LATENCY-1];
  assign ram_read_data_o = d_q[LATENCY-1];
  always_ff @(posedge clk_i)
    if (acc_w && wr_w && in_range_w)
      for (int b = 0; b < 4; b++)
        if (ram_wr_i[b]) mem[idx_w][b*8 +: 8] <= ram_write_data_i[b*8 +: 8];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q <= '0;
      v_q <= '0;
      e_q <= '0;
      d_q <= '0;
    end else begin
      cnt_q <= cnt_q + 3'(acc_w) - 3'(ram_ack_o);
      for (int i = LATENCY - 1; i > 0; i--) begin
        v_q[i] <= v_q[i-1];
        e_q[i] <= e_q[i-1];
        d_q[i] <= d_q[i-1];
      end
      v_q[0] <= acc_w;
      e_q[0] <= acc_w && !in_range_w;
      d_q[0] <= (acc_w && !wr_w && in_range_w) ? mem[idx_w] : '0;
    end
endmodule

// File: tb/tb_axi4_pmem_ram_backend.sv
// tb_axi4_pmem_ram_backend: scoreboarded bench driving a LATENCY=2 and a LATENCY=6 instance
module tb_axi4_pmem_ram_backend;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [3:0] wr [2];
  logic rd [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic stall [2];
  logic acc [2];
  logic ack [2];
  logic err [2];
  logic [31:0] rdata [2];
  logic [7:0] len = 8'h00;
  int n_chk = 0;
  int n_pass = 0;
  int n_acc [2] = '{0, 0};
  int n_ack [2] = '{0, 0};
  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  axi4_pmem_ram_backend #(.LATENCY(2), .MAX_OUTSTANDING(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .ram_wr_i(wr[0]), .ram_rd_i(rd[0]), .ram_len_i(len),
    .ram_addr_i(addr[0]), .ram_write_data_i(wdata[0]), .stall_i(stall[0]),
    .ram_accept_o(acc[0]), .ram_ack_o(ack[0]), .ram_error_o(err[0]), .ram_read_data_o(rdata[0])
  );
  axi4_pmem_ram_backend #(.LATENCY(6), .MAX_OUTSTANDING(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .ram_wr_i(wr[1]), .ram_rd_i(rd[1]), .ram_len_i(len),
    .ram_addr_i(addr[1]), .ram_write_data_i(wdata[1]), .stall_i(stall[1]),
    .ram_accept_o(acc[1]), .ram_ack_o(ack[1]), .ram_error_o(err[1]), .ram_read_data_o(rdata[1])
  );
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int LAT = (g == 0) ? 2 : 6;
    exp_t q [$];
    exp_t e;
    logic [31:0] model [int];
    logic [31:0] wd;
    int cyc = 0;
    int idx;
    always @(negedge clk) begin
      if (!rst_n) q.delete();
      else begin
        cyc++;
        if (ack[g]) begin
          n_ack[g]++;
          if (q.size() == 0) chk("ack_spurious", 64'(ack[g]), 64'd0);
          else begin
            e = q.pop_front();
            chk("ack_cycle", 64'(cyc), 64'(e.cyc));
            chk("ack_err", 64'(err[g]), 64'(e.err));
            chk("ack_data", 64'(rdata[g]), 64'(e.data));
          end
        end else chk("idle_zero", {31'd0, err[g], rdata[g]}, 64'd0);
        if (acc[g] && (rd[g] || wr[g] != 4'h0)) begin
          n_acc[g]++;
          idx = int'(addr[g][15:2]);
          e.cyc = 32'(cyc + LAT);
          e.err = addr[g] >= 32'h0001_0000;
          e.data = 32'h0;
          if (!e.err && wr[g] != 4'h0) begin
            wd = model.exists(idx) ? model[idx] : 32'h0;
            for (int b = 0; b < 4; b++)
              if (wr[g][b]) wd[b*8 +: 8] = wdata[g][b*8 +: 8];
            model[idx] = wd;
          end else if (!e.err) e.data = model[idx];
          q.push_back(e);
        end
      end
    end
  end
  task automatic issue(input int g, input logic [3:0] s, input logic r, input logic [31:0] a,
                       input logic [31:0] d, output int w);
    wr[g] = s;
    rd[g] = r;
    addr[g] = a;
    wdata[g] = d;
    w = 0;
    @(negedge clk);
    while (!acc[g] && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!acc[g]) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    wr[g] = 4'h0;
    rd[g] = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int w, out, peak, cnt;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      wr[g] = 4'h0; rd[g] = 1'b0; addr[g] = 32'h0; wdata[g] = 32'h0; stall[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ack_a", 64'(ack[0]), 64'd0);
    chk("rst_err_a", 64'(err[0]), 64'd0);
    chk("rst_data_a", 64'(rdata[0]), 64'd0);
    chk("rst_acc_a", 64'(acc[0]), 64'd1);
    chk("rst_ack_b", 64'(ack[1]), 64'd0);
    chk("rst_acc_b", 64'(acc[1]), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(0, 4'hF, 1'b0, 32'h100, 32'hDEADBEEF, w);
    issue(0, 4'h0, 1'b1, 32'h100, 32'h0, w);
    chk("t1_rd_wait", 64'(w), 64'd0);
    idle(6);
    issue(0, 4'hF, 1'b0, 32'h200, 32'hAABBCCDD, w);
    issue(0, 4'b0101, 1'b0, 32'h200, 32'h11223344, w);
    issue(0, 4'h0, 1'b1, 32'h200, 32'h0, w);
    idle(6);
    for (int i = 0; i < 8; i++) issue(0, 4'hF, 1'b0, 32'(i * 4), 32'(i), w);
    idle(6);
    for (int i = 0; i < 8; i++) begin
      issue(0, 4'h0, 1'b1, 32'(i * 4), 32'h0, w);
      chk("t3_acc_wait", 64'(w), 64'd0);
    end
    idle(6);
    issue(1, 4'hF, 1'b0, 32'h0, 32'h5A, w);
    idle(10);
    rd[1] = 1'b1;
    addr[1] = 32'h0;
    out = 0;
    peak = 0;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      chk("t4_acc", 64'(acc[1]), 64'((k % 7) < 4));
      if (out > peak) peak = out;
      out = out + int'(acc[1]) - int'(ack[1]);
    end
    @(posedge clk);
    #1 rd[1] = 1'b0;
    idle(12);
    chk("t4_peak", 64'(peak), 64'd4);
    chk("t4_lost", 64'(n_ack[1]), 64'(n_acc[1]));
    issue(0, 4'h0, 1'b1, 32'h0001_0000, 32'h0, w);
    issue(0, 4'hF, 1'b0, 32'h0001_0004, 32'hFFFF_FFFF, w);
    idle(6);
    issue(0, 4'h0, 1'b1, 32'h0, 32'h0, w);
    issue(0, 4'h0, 1'b1, 32'h4, 32'h0, w);
    idle(6);
    issue(0, 4'h0, 1'b1, 32'h8, 32'h0, w);
    issue(0, 4'h0, 1'b1, 32'hC, 32'h0, w);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    @(negedge clk);
    chk("t6_rst_acc", 64'(acc[0]), 64'd1);
    for (int k = 0; k < 6; k++) begin
      if (ack[0]) cnt++;
      @(negedge clk);
    end
    chk("t6_no_ack", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;
    stall[0] = 1'b1;
    rd[0] = 1'b1;
    addr[0] = 32'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_stall_acc", 64'(acc[0]), 64'd0);
      @(posedge clk);
      #1;
    end
    stall[0] = 1'b0;
    @(negedge clk);
    chk("t6_unstall_acc", 64'(acc[0]), 64'd1);
    @(posedge clk);
    #1 rd[0] = 1'b0;
    idle(8);
    chk("t6_acks", 64'(n_ack[0]), 64'(n_acc[0] - 2));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
